// File: rtl/scan_pkg.sv
// Shared definitions for the scan sequencer.
// Holds the channel count, the select width, the default blanking length
// and the sequencer state enum.
package scan_pkg;

  localparam int unsigned NUM_CH        = 8;
  localparam int unsigned CH_W          = 3;
  localparam int unsigned BLANK_CYC_DEF = 2;

  typedef enum logic [1:0] {
    StIdle,
    StBlank,
    StDwell
  } scan_state_e;

endpackage

// File: rtl/scan_next_sel.sv
// Rotating priority search for the next enabled channel.
// Ports:
//   i_mask  - per-channel enable bits
//   i_cur   - current channel index
//   o_next  - first set mask bit strictly after i_cur, wrapping 7 -> 0
//             (returns i_cur itself when it is the only set bit)
//   o_wrap  - next index <= current index (the search wrapped)
//   o_none  - mask is all zero; o_next is then meaningless
module scan_next_sel
  import scan_pkg::*;
(
  input  logic [NUM_CH-1:0] i_mask,
  input  logic [CH_W-1:0]   i_cur,
  output logic [CH_W-1:0]   o_next,
  output logic              o_wrap,
  output logic              o_none
);

  always_comb begin
    logic            v_found;
    logic [CH_W-1:0] v_idx;
    o_next  = i_cur;
    v_found = 1'b0;
    v_idx   = '0;
    // Offsets 1..NUM_CH; the 3-bit add wraps naturally, offset 8 is i_cur.
    for (int k = 1; k <= NUM_CH; k++) begin
      v_idx = i_cur + CH_W'(k);
      if (!v_found && i_mask[v_idx]) begin
        o_next  = v_idx;
        v_found = 1'b1;
      end
    end
    o_none = (i_mask == '0);
    o_wrap = (o_next <= i_cur);
  end

endmodule

// File: rtl/scan_sequencer.sv
// Scan sequencer driving a 3-to-8 active-low decoder.
// Cycles through the enabled channels: each channel gets BLANK_CYC cycles
// with the decoder disabled, then 'dwell' cycles with it enabled.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   run         - level request to scan
//   mask        - per-channel enable
//   dwell       - enabled cycles per channel (0 treated as 1)
//   a           - decoder select
//   e           - decoder disable (1 = all outputs inactive)
//   busy        - sequencer not idle
//   frame_done  - pulse after the last enabled channel's dwell of a frame
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int unsigned BLANK_CYC = BLANK_CYC_DEF,
  parameter int unsigned DWELL_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [NUM_CH-1:0]  mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [CH_W-1:0]    a,
  output logic               e,
  output logic               busy,
  output logic               frame_done
);

  localparam logic [3:0] BlankLast = 4'(BLANK_CYC - 1);
  // With a single blanking cycle there is no edge with e=1 on both sides,
  // so the select has to move together with the decoder being disabled.
  localparam bit EarlyLoad = (BLANK_CYC == 1);

  scan_state_e        r_state;
  logic [CH_W-1:0]    r_a;
  logic [CH_W-1:0]    r_ch;     // channel a is heading for during blanking
  logic               r_e;
  logic               r_busy;
  logic               r_fd;
  logic [3:0]         r_bcnt;
  logic [DWELL_W-1:0] r_dcnt;

  logic [CH_W-1:0]    w_cur;
  logic [CH_W-1:0]    w_next;
  logic               w_wrap;
  logic               w_none;

  // From idle, searching after channel 7 yields the lowest set bit.
  assign w_cur = (r_state == StIdle) ? CH_W'(NUM_CH - 1) : r_a;

  scan_next_sel u_next_sel (
    .i_mask (mask),
    .i_cur  (w_cur),
    .o_next (w_next),
    .o_wrap (w_wrap),
    .o_none (w_none)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_ch    <= '0;
      r_e     <= 1'b1;
      r_busy  <= 1'b0;
      r_fd    <= 1'b0;
      r_bcnt  <= '0;
      r_dcnt  <= '0;
    end else begin
      r_fd <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_e    <= 1'b1;
          r_busy <= 1'b0;
          if (run && !w_none) begin
            r_a     <= w_next;
            r_ch    <= w_next;
            r_bcnt  <= BlankLast;
            r_busy  <= 1'b1;
            r_state <= StBlank;
          end
        end
        StBlank: begin
          if (r_bcnt == '0) begin
            r_e     <= 1'b0;
            r_dcnt  <= (dwell == '0) ? '0 : dwell - DWELL_W'(1);
            r_state <= StDwell;
          end else begin
            // Only edges with e=1 on both sides may move the select.
            r_bcnt <= r_bcnt - 4'd1;
            r_a    <= r_ch;
          end
        end
        StDwell: begin
          if (r_dcnt == '0) begin
            r_e <= 1'b1;
            if (!w_none) r_fd <= w_wrap;
            if (!run || w_none) begin
              r_busy  <= 1'b0;
              r_state <= StIdle;
            end else begin
              r_ch    <= w_next;
              if (EarlyLoad) r_a <= w_next;
              r_bcnt  <= BlankLast;
              r_state <= StBlank;
            end
          end else begin
            r_dcnt <= r_dcnt - DWELL_W'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign a          = r_a;
  assign e          = r_e;
  assign busy       = r_busy;
  assign frame_done = r_fd;

endmodule

// File: tb/tb_scan_sequencer.sv
module tb_scan_sequencer;

  localparam int BLANK_CYC = 2;
  localparam int DWELL_W   = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               run;
  logic [7:0]         mask;
  logic [DWELL_W-1:0] dwell;
  logic [2:0]         a;
  logic               e;
  logic               busy;
  logic               frame_done;

  scan_sequencer #(
    .BLANK_CYC (BLANK_CYC),
    .DWELL_W   (DWELL_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .mask       (mask),
    .dwell      (dwell),
    .a          (a),
    .e          (e),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] ch;
    int         len;
    logic       fd;
  } rec_t;

  rec_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   dwell_starts = 0;
  int   seg_id = 0;
  int   exp_period = 0;

  task automatic chk(input string nm, input longint act, input longint expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // Select must hold while the decoder stays enabled.
  a_sel_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (!e && !$past(e)) |-> $stable(a));

  // Monitor: pairs each dwell burst (e low) with the next expected record.
  logic       prev_e = 1'b1;
  logic [2:0] prev_a = '0;
  int         burst_len = 0;
  int         blank_run = 0;
  bit         have_rec = 0;
  rec_t       cur;
  longint     cyc = 0;
  longint     fd_cyc = 0;
  int         fd_seg = -1;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_e    = 1'b1;
      burst_len = 0;
      blank_run = 0;
      have_rec  = 0;
    end else begin
      if (!e && !prev_e) chk("a_stable_in_dwell", a, prev_a);
      if (!e && prev_e) begin
        dwell_starts++;
        chk("blank_len", blank_run, BLANK_CYC);
        chk("busy_in_dwell", busy, 1);
        blank_run = 0;
        chk("unexpected_dwell", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          cur      = exp_q.pop_front();
          have_rec = 1;
          chk("dwell_channel", a, cur.ch);
        end else begin
          have_rec = 0;
        end
        burst_len = 1;
      end else if (!e) begin
        burst_len++;
      end
      if (e && !prev_e) begin
        if (have_rec) begin
          chk("dwell_len", burst_len, cur.len);
          chk("frame_done", frame_done, cur.fd);
        end
        if (frame_done) begin
          if (fd_seg == seg_id) chk("fd_period", cyc - fd_cyc, exp_period);
          fd_seg = seg_id;
          fd_cyc = cyc;
        end
      end else if (frame_done) begin
        chk("fd_spurious", frame_done, 0);
      end
      if (!busy) blank_run = 0;
      else if (e) blank_run++;
      prev_e = e;
      prev_a = a;
    end
  end

  // Reference: enabled channels visited in ascending order, cycling; the
  // frame ends after the highest enabled channel.
  task automatic run_seg(input logic [7:0] m, input int d, input int k);
    int   chans[$];
    int   len;
    int   target;
    int   bound;
    rec_t r;
    for (int i = 0; i < 8; i++) if (m[i]) chans.push_back(i);
    len = (d == 0) ? 1 : d;
    for (int n = 0; n < k; n++) begin
      r.ch  = 3'(chans[n % chans.size()]);
      r.len = len;
      r.fd  = ((n % chans.size()) == chans.size() - 1);
      exp_q.push_back(r);
    end
    exp_period = chans.size() * (BLANK_CYC + len);
    seg_id++;
    @(negedge clk); #1;
    mask   = m;
    dwell  = DWELL_W'(d);
    run    = 1'b1;
    target = dwell_starts + k;
    bound  = 0;
    while (dwell_starts < target && bound < 5000) begin
      @(negedge clk); #1;
      bound++;
    end
    chk("dwell_wait_ok", bound < 5000, 1);
    // Dropped during the last wanted dwell: it must still run to completion.
    run   = 1'b0;
    bound = 0;
    while (busy && bound < 5000) begin
      @(negedge clk); #1;
      bound++;
    end
    chk("idle_wait_ok", bound < 5000, 1);
    chk("idle_e", e, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("idle_busy", busy, 0);
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    run   = 1'b0;
    mask  = '0;
    dwell = '0;
    repeat (3) @(negedge clk);
    chk("rst_a", a, 0);
    chk("rst_e", e, 1);
    chk("rst_busy", busy, 0);
    chk("rst_fd", frame_done, 0);
    #1 rst_n = 1'b1;

    run_seg(8'hFF, 3, 17);
    run_seg(8'b1010_0100, 1, 7);
    run_seg(8'h10, 0, 6);
    run_seg(8'b0001_1000, 10, 1);
    for (int s = 0; s < 10; s++)
      run_seg(8'($urandom_range(1, 255)), $urandom_range(0, 5), $urandom_range(1, 12));

    // Reset in the middle of a dwell.
    r_push_first();
    @(negedge clk); #1;
    mask  = 8'hFF;
    dwell = DWELL_W'(8);
    run   = 1'b1;
    begin
      int st;
      int bound;
      st    = dwell_starts;
      bound = 0;
      while (dwell_starts == st && bound < 1000) begin
        @(negedge clk); #1;
        bound++;
      end
      chk("rst_dwell_wait_ok", bound < 1000, 1);
    end
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_e", e, 1);
    chk("rst_mid_a", a, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_fd", frame_done, 0);
    exp_q.delete();
    @(negedge clk); #1;
    mask  = 8'h00;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("mask0_busy", busy, 0);
      chk("mask0_e", e, 1);
    end
    run = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  task automatic r_push_first();
    rec_t r;
    r.ch  = 3'd0;
    r.len = 8;
    r.fd  = 1'b0;
    exp_q.push_back(r);
  endtask

endmodule
